// File: rtl/mining_controller.sv
// Mining job controller: receives a job frame, sweeps the nonce range through an
// external hash core and reports shares, range exhaustion and malformed frames.
module mining_controller #(
    parameter int unsigned DIFF_ZERO_BITS = 32,
    parameter logic [31:0] NONCE_LAST     = 32'hFFFF_FFFF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           chip_enable,
    input  logic [0:767]   rx_data,
    input  logic           hash_done,
    input  logic [255:0]   hash_out,
    output logic           hash_start,
    output logic [0:255]   hash_midstate,
    output logic [0:511]   hash_block,
    output logic           found_valid,
    output logic [31:0]    found_nonce,
    output logic           exhausted,
    output logic           frame_error,
    output logic           busy
);

    localparam int unsigned FRAME_BITS = 768;
    localparam int unsigned CNT_W      = 10;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               ce_prev;
    logic [CNT_W-1:0]   bit_cnt;
    logic               pending;
    logic [255:0]       hash_q;

    logic               frame_end_c;
    logic               frame_ok_c;
    logic               share_c;
    logic [31:0]        nonce_c;

    logic               load_job;
    logic               pending_set;
    logic               pending_clr;
    logic               capture;
    logic               step;
    logic               share_hit;
    logic               last_hit;

    // The live nonce is kept in place inside the block sent to the core.
    assign nonce_c     = hash_block[96:127];
    assign frame_end_c = chip_enable & ~ce_prev;
    assign frame_ok_c  = frame_end_c && (bit_cnt == FRAME_CNT);
    assign share_c     = (hash_q[255 -: DIFF_ZERO_BITS] == '0);

    generate
        if (DIFF_ZERO_BITS < 256) begin : g_low_bits
            logic unused_hash_low;
            assign unused_hash_low = ^hash_q[255-DIFF_ZERO_BITS:0];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt   = state;
        load_job    = 1'b0;
        pending_set = 1'b0;
        pending_clr = 1'b0;
        capture     = 1'b0;
        step        = 1'b0;
        share_hit   = 1'b0;
        last_hit    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (frame_ok_c) begin
                    load_job  = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (frame_ok_c) begin
                    load_job  = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                load_job = frame_ok_c;
                if (hash_done) begin
                    // A job replaced while hashing makes the in-flight result stale.
                    pending_clr = 1'b1;
                    if (pending || frame_ok_c) begin
                        state_nxt = ST_START;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_CHECK;
                    end
                end else if (frame_ok_c) begin
                    pending_set = 1'b1;
                end
            end
            ST_CHECK: begin
                if (frame_ok_c) begin
                    load_job  = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    share_hit = share_c;
                    if (nonce_c == NONCE_LAST) begin
                        last_hit  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        step      = 1'b1;
                        state_nxt = ST_START;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame receiver, job registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_prev       <= 1'b1;
            bit_cnt       <= '0;
            pending       <= 1'b0;
            hash_q        <= '0;
            hash_midstate <= '0;
            hash_block    <= '0;
            hash_start    <= 1'b0;
            found_valid   <= 1'b0;
            found_nonce   <= '0;
            exhausted     <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            ce_prev <= chip_enable;
            if (chip_enable) begin
                bit_cnt <= '0;
            end else if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (pending_set) begin
                pending <= 1'b1;
            end else if (pending_clr) begin
                pending <= 1'b0;
            end

            if (capture) begin
                hash_q <= hash_out;
            end

            // The nonce field of the received block is the start nonce.
            if (load_job) begin
                hash_midstate <= rx_data[0:255];
                hash_block    <= rx_data[256:767];
            end else if (step) begin
                hash_block[96:127] <= nonce_c + 32'd1;
            end

            if (share_hit) begin
                found_nonce <= nonce_c;
            end

            hash_start  <= (state_nxt == ST_START);
            busy        <= (state_nxt inside {ST_START, ST_WAIT, ST_CHECK});
            found_valid <= share_hit;
            exhausted   <= last_hit;
            frame_error <= frame_end_c && !frame_ok_c;
        end
    end

endmodule

// File: tb/tb_mining_controller.sv
// Self-checking bench for mining_controller: table-driven and randomized jobs against
// a nonce-sweep reference model, plus hand-timed replacement and reset sequences.
module tb_mining_controller;

    localparam logic [31:0] NONCE_LAST = 32'h12;

    logic           clk = 1'b0;
    logic           rst;
    logic           chip_enable;
    logic [0:767]   rx_data;
    logic           hash_done;
    logic [255:0]   hash_out;
    logic           hash_start;
    logic [0:255]   hash_midstate;
    logic [0:511]   hash_block;
    logic           found_valid;
    logic [31:0]    found_nonce;
    logic           exhausted;
    logic           frame_error;
    logic           busy;

    mining_controller #(
        .DIFF_ZERO_BITS (32),
        .NONCE_LAST     (NONCE_LAST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chip_enable   (chip_enable),
        .rx_data       (rx_data),
        .hash_done     (hash_done),
        .hash_out      (hash_out),
        .hash_start    (hash_start),
        .hash_midstate (hash_midstate),
        .hash_block    (hash_block),
        .found_valid   (found_valid),
        .found_nonce   (found_nonce),
        .exhausted     (exhausted),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start;
        int unsigned len;
        int unsigned modv;
        int unsigned remv;
        int unsigned lat;
        int unsigned exp_starts;
        int unsigned exp_found;
        int unsigned exp_exh;
        int unsigned exp_ferr;
    } row_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    logic [31:0] st_nonce[$];
    logic [0:255] st_mid[$];
    int          st_cyc[$];
    logic [31:0] fv_nonce[$];
    int          fv_cyc[$];
    int          ex_cyc[$];
    int          ferr_n;

    bit          core_auto = 1'b0;
    bit          core_busy = 1'b0;
    int          core_cnt  = 0;
    logic [31:0] core_nonce;
    int unsigned cur_mod = 1;
    int unsigned cur_rem = 0;
    int unsigned cur_lat = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_share(input logic [31:0] n);
        return (n % 32'(cur_mod)) == 32'(cur_rem);
    endfunction

    // Shares have 32 leading zeros; non-shares always carry a one in the top word.
    function automatic logic [255:0] hash_fn(input logic [31:0] n);
        logic [31:0] top;
        top = is_share(n) ? 32'h0 : (32'h1 << n[4:0]);
        return {top, {7{n ^ 32'hA5A5_5A5A}}};
    endfunction

    task automatic clear_logs();
        st_nonce.delete(); st_mid.delete(); st_cyc.delete();
        fv_nonce.delete(); fv_cyc.delete(); ex_cyc.delete();
        ferr_n = 0;
    endtask

    // One clock: sample outputs just after the edge, then update the hash-core model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        hash_done = 1'b0;
        if (core_busy) begin
            core_cnt--;
            if (core_cnt <= 0) begin
                hash_done = 1'b1;
                hash_out  = hash_fn(core_nonce);
                core_busy = 1'b0;
            end
        end
        if (hash_start) begin
            st_nonce.push_back(hash_block[96:127]);
            st_mid.push_back(hash_midstate);
            st_cyc.push_back(cyc);
            if (core_auto) begin
                core_busy  = 1'b1;
                core_cnt   = int'(cur_lat);
                core_nonce = hash_block[96:127];
            end
        end
        if (found_valid) begin
            fv_nonce.push_back(found_nonce);
            fv_cyc.push_back(cyc);
        end
        if (exhausted) ex_cyc.push_back(cyc);
        if (frame_error) ferr_n++;
    endtask

    task automatic send_frame(input logic [0:255] m, input logic [0:511] b,
                              input int unsigned n, input bit done_at_end);
        rx_data     = {m, b};
        chip_enable = 1'b0;
        repeat (n) tick();
        chip_enable = 1'b1;
        if (done_at_end) begin
            hash_done = 1'b1;
            hash_out  = '0;
        end
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_hash_start"},  64'(hash_start), 64'd0);
        check({tag, "_busy"},        64'(busy), 64'd0);
        check({tag, "_found_valid"}, 64'(found_valid), 64'd0);
        check({tag, "_exhausted"},   64'(exhausted), 64'd0);
        check({tag, "_frame_error"}, 64'(frame_error), 64'd0);
        check({tag, "_found_nonce"}, 64'(found_nonce), 64'd0);
        check({tag, "_job_zero"},    64'((hash_midstate == '0) && (hash_block == '0)), 64'd1);
    endtask

    task automatic run_job(input row_t r, input bit use_tab);
        logic [0:255] mid;
        logic [0:511] blk;
        logic [31:0]  exp_n[$];
        logic [31:0]  exp_f[$];
        logic [31:0]  n;
        bit           ok;
        bit           finished;
        bit           same;

        mid = {8{$urandom()}};
        blk = {16{$urandom()}};
        blk[96:127] = r.start;
        cur_mod = r.modv;
        cur_rem = r.remv;
        cur_lat = r.lat;
        core_auto = 1'b1;
        clear_logs();
        send_frame(mid, blk, r.len, 1'b0);

        finished = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (!busy && !core_busy) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        check("scan_timeout", 64'(finished), 64'd1);
        repeat (3) tick();

        // Reference: every nonce from start up to NONCE_LAST, modulo 2^32.
        if (r.len == 768) begin
            n = r.start;
            forever begin
                exp_n.push_back(n);
                if (is_share(n)) exp_f.push_back(n);
                if (n == NONCE_LAST) break;
                n = n + 32'd1;
            end
        end

        check("start_count", 64'(st_nonce.size()), 64'(exp_n.size()));
        ok = (st_nonce.size() == exp_n.size());
        foreach (exp_n[i]) if (ok && st_nonce[i] !== exp_n[i]) ok = 1'b0;
        check("nonce_order", 64'(ok), 64'd1);

        check("found_count", 64'(fv_nonce.size()), 64'(exp_f.size()));
        ok = (fv_nonce.size() == exp_f.size());
        foreach (exp_f[i]) if (ok && fv_nonce[i] !== exp_f[i]) ok = 1'b0;
        check("found_nonces", 64'(ok), 64'd1);

        check("exhausted_count", 64'(ex_cyc.size()), 64'((r.len == 768) ? 1 : 0));
        check("frame_error_count", 64'(ferr_n), 64'((r.len != 768) ? 1 : 0));

        ok = 1'b1;
        for (int i = 1; i < st_cyc.size(); i++)
            if (st_cyc[i] - st_cyc[i-1] != int'(r.lat) + 2) ok = 1'b0;
        foreach (st_mid[i]) if (st_mid[i] !== mid) ok = 1'b0;
        check("period_and_midstate", 64'(ok), 64'd1);

        if (r.len == 768) begin
            same = (fv_cyc.size() > 0) && (ex_cyc.size() > 0) && (fv_cyc[$] == ex_cyc[0]);
            check("last_share_same_cycle", 64'(same), 64'(is_share(NONCE_LAST)));
            if (exp_f.size() > 0) check("found_nonce_final", 64'(found_nonce), 64'(exp_f[$]));
        end
        check("busy_after", 64'(busy), 64'd0);

        if (use_tab) begin
            check("tab_starts", 64'(st_nonce.size()), 64'(r.exp_starts));
            check("tab_found",  64'(fv_nonce.size()), 64'(r.exp_found));
            check("tab_exh",    64'(ex_cyc.size()),   64'(r.exp_exh));
            check("tab_ferr",   64'(ferr_n),          64'(r.exp_ferr));
        end
        core_auto = 1'b0;
    endtask

    initial begin
        row_t tab[7];
        row_t r;
        logic [0:255] m_a, m_b, m_c;
        logic [0:511] b_a, b_b, b_c;

        tab[0] = '{32'h10,        768,  256, 17, 2,  3,  1, 1, 0};
        tab[1] = '{32'h10,        767,  256, 17, 2,  0,  0, 0, 1};
        tab[2] = '{32'h10,        769,  256, 17, 2,  0,  0, 0, 1};
        tab[3] = '{32'h12,        768,  1,   0,  1,  1,  1, 1, 0};
        tab[4] = '{32'hFFFF_FFFE, 768,  2,   0,  3,  21, 11, 1, 0};
        tab[5] = '{32'h0,         1100, 1,   0,  1,  0,  0, 0, 1};
        tab[6] = '{32'h0,         768,  5,   3,  4,  19, 4, 1, 0};

        rst = 1'b1; chip_enable = 1'b1; rx_data = '0; hash_done = 1'b0; hash_out = '0;
        clear_logs();
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        foreach (tab[i]) run_job(tab[i], 1'b1);

        for (int k = 0; k < 8; k++) begin
            r.len  = 768;
            r.start = ($urandom_range(0, 1) == 0) ? NONCE_LAST - 32'($urandom_range(0, 10))
                                                   : 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
            r.modv = $urandom_range(1, 4);
            r.remv = $urandom_range(0, r.modv - 1);
            r.lat  = $urandom_range(1, 5);
            r.exp_starts = 0; r.exp_found = 0; r.exp_exh = 0; r.exp_ferr = 0;
            run_job(r, 1'b0);
        end

        // Job replaced while the core is hashing: stale zero hash must not report.
        core_auto = 1'b0;
        m_a = {8{$urandom()}}; b_a = {16{$urandom()}}; b_a[96:127] = 32'h5;
        m_b = {8{$urandom()}}; b_b = {16{$urandom()}}; b_b[96:127] = 32'h9;
        m_c = {8{$urandom()}}; b_c = {16{$urandom()}}; b_c[96:127] = 32'hC;
        clear_logs();
        send_frame(m_a, b_a, 768, 1'b0);
        check("wait_first_start", 64'(st_nonce.size()), 64'd1);
        repeat (2) tick();
        check("wait_busy", 64'(busy), 64'd1);
        clear_logs();
        send_frame(m_b, b_b, 768, 1'b0);
        tick();
        check("pending_no_start", 64'(st_nonce.size()), 64'd0);
        hash_done = 1'b1; hash_out = '0;
        tick();
        repeat (3) tick();
        check("pending_no_found", 64'(fv_nonce.size()), 64'd0);
        check("pending_one_start", 64'(st_nonce.size()), 64'd1);
        check("pending_nonce", 64'((st_nonce.size() > 0) ? st_nonce[0] : 32'hDEAD_BEEF), 64'h9);
        check("pending_mid", 64'((st_mid.size() > 0) && (st_mid[0] === m_b)), 64'd1);

        // Frame end and hash_done in the same WAIT cycle.
        clear_logs();
        send_frame(m_c, b_c, 768, 1'b1);
        repeat (3) tick();
        check("samecyc_no_found", 64'(fv_nonce.size()), 64'd0);
        check("samecyc_one_start", 64'(st_nonce.size()), 64'd1);
        check("samecyc_nonce", 64'((st_nonce.size() > 0) ? st_nonce[0] : 32'hDEAD_BEEF), 64'hC);
        check("samecyc_mid", 64'((st_mid.size() > 0) && (st_mid[0] === m_c)), 64'd1);

        // Reset while waiting on the core; a late hash_done is ignored.
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("rst_wait");
        clear_logs();
        hash_done = 1'b1; hash_out = '0;
        tick();
        repeat (5) tick();
        check("rst_no_start", 64'(st_nonce.size()), 64'd0);
        check("rst_no_found", 64'(fv_nonce.size() + ex_cyc.size()), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
